// File: rtl/osd_text_scanout.sv
// osd_text_scanout
// Video-side reader for the OSD text VRAM. For each requested scanline it walks
// one text row of the character map through the byte-wide VRAM video port,
// looks up the matching glyph row in the font ROM and serialises it one pixel
// per ce_pixel. The next character is fetched in the background while the
// current one is shifted out.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   ce_pixel             pixel enable (at most one pulse per 2 clk)
//   frame_start          restart at text row 0 / scanline 0
//   line_start           render one OSD scanline
//   vram_addr, vram_rd   byte read request to the VRAM video port
//   vram_data            VRAM byte, valid the clk after the request
//   font_addr, font_rd   glyph row request {code[6:0], scanline}
//   font_data            glyph row (MSB leftmost), valid the clk after request
//   pixel                current pixel, inverted when the code has bit 7 set
//   active               high while pixels of the current line are output
//   frame_done           high once every scanline of the frame is rendered
module osd_text_scanout #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE       = 0,
  parameter int COLS       = 32,
  parameter int ROWS       = 8,
  parameter int CHAR_H     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_pixel,
  input  logic                  frame_start,
  input  logic                  line_start,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_rd,
  input  logic [7:0]            vram_data,
  output logic [9:0]            font_addr,
  output logic                  font_rd,
  input  logic [7:0]            font_data,
  output logic                  pixel,
  output logic                  active,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_C, S_WAIT_C, S_FETCH_F, S_WAIT_F, S_RUN
  } state_t;

  state_t r_state, w_next;

  logic [ROW_W-1:0] r_row;
  logic [2:0]       r_scan;
  logic [COL_W-1:0] r_col;       // index of the next character to fetch/load
  logic             r_done;
  logic             r_first;     // RUN entry cycle: buffer -> shifter
  logic             r_pf_busy;
  logic [1:0]       r_pf_step;   // 0 fetch code, 1 wait, 2 fetch glyph, 3 wait
  logic             r_buf_full;
  logic [2:0]       r_pix;

  logic [7:0] r_code;
  logic [7:0] r_buf;
  logic       r_inv_buf;
  logic [7:0] r_shift;
  logic       r_inv;

  logic w_run, w_show;
  logic w_pf_fc, w_pf_wc, w_pf_ff, w_pf_wf;
  logic w_vram_rd, w_font_rd, w_cap_code, w_cap_font;
  logic w_boundary, w_last, w_eol, w_scan_last;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_run   = (r_state == S_RUN);
  assign w_show  = w_run && !r_first;

  assign w_pf_fc = w_show && r_pf_busy && (r_pf_step == 2'd0);
  assign w_pf_wc = w_show && r_pf_busy && (r_pf_step == 2'd1);
  assign w_pf_ff = w_show && r_pf_busy && (r_pf_step == 2'd2);
  assign w_pf_wf = w_show && r_pf_busy && (r_pf_step == 2'd3);

  assign w_vram_rd  = (r_state == S_FETCH_C) || w_pf_fc;
  assign w_font_rd  = (r_state == S_FETCH_F) || w_pf_ff;
  assign w_cap_code = (r_state == S_WAIT_C)  || w_pf_wc;
  assign w_cap_font = (r_state == S_WAIT_F)  || w_pf_wf;

  assign w_boundary  = w_show && ce_pixel && (r_pix == 3'd7);
  assign w_last      = (r_col == COL_W'(COLS));
  assign w_eol       = w_boundary && w_last;
  assign w_scan_last = (r_scan == 3'(CHAR_H - 1));

  // Address arithmetic is done at ADDR_WIDTH so it wraps modulo 2^ADDR_WIDTH.
  assign w_addr = ADDR_WIDTH'(BASE) + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(COLS)
                + ADDR_WIDTH'(r_col);

  assign vram_rd    = w_vram_rd;
  assign vram_addr  = w_vram_rd ? w_addr : '0;
  assign font_rd    = w_font_rd;
  assign font_addr  = w_font_rd ? {r_code[6:0], r_scan} : 10'd0;
  assign active     = w_show;
  assign pixel      = w_show && (r_shift[7] ^ r_inv);
  assign frame_done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (frame_start) begin
      // A line_start in the same clk is honoured after the restart.
      w_next = line_start ? S_FETCH_C : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (line_start && !r_done) w_next = S_FETCH_C;
        S_FETCH_C: w_next = S_WAIT_C;
        S_WAIT_C:  w_next = S_FETCH_F;
        S_FETCH_F: w_next = S_WAIT_F;
        S_WAIT_F:  w_next = S_RUN;
        S_RUN:     if (w_eol) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row      <= '0;
      r_scan     <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
      r_pf_busy  <= 1'b0;
      r_pf_step  <= '0;
      r_buf_full <= 1'b0;
      r_pix      <= '0;
    end else if (frame_start) begin
      r_row      <= '0;
      r_scan     <= '0;
      r_col      <= '0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
      r_pf_busy  <= 1'b0;
      r_pf_step  <= '0;
      r_buf_full <= 1'b0;
      r_pix      <= '0;
    end else begin
      case (r_state)
        S_WAIT_F: begin
          r_first    <= 1'b1;
          r_pix      <= '0;
          r_buf_full <= 1'b0;
          r_pf_busy  <= 1'b0;
        end
        S_RUN: begin
          if (r_first) begin
            r_first <= 1'b0;
            r_col   <= r_col + 1'b1;
          end else begin
            // Background fetch of character r_col; finishes long before the
            // next character boundary since ce_pixel is at most every 2 clk.
            if (r_pf_busy) begin
              r_pf_step <= r_pf_step + 1'b1;
              if (r_pf_step == 2'd3) begin
                r_pf_busy  <= 1'b0;
                r_buf_full <= 1'b1;
              end
            end else if (!r_buf_full && (r_col < COL_W'(COLS))) begin
              r_pf_busy <= 1'b1;
              r_pf_step <= '0;
            end
            if (ce_pixel) begin
              r_pix <= r_pix + 1'b1;
              if (r_pix == 3'd7) begin
                if (w_last) begin
                  r_col <= '0;
                  if (w_scan_last) begin
                    r_scan <= '0;
                    r_row  <= r_row + 1'b1;
                    if (r_row == ROW_W'(ROWS - 1)) r_done <= 1'b1;
                  end else begin
                    r_scan <= r_scan + 1'b1;
                  end
                end else begin
                  r_buf_full <= 1'b0;
                  r_col      <= r_col + 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: contents only matter while qualified by the control above.
  always_ff @(posedge clk) begin
    if (w_cap_code) r_code <= vram_data;
    if (w_font_rd)  r_inv_buf <= r_code[7];
    if (w_cap_font) r_buf <= font_data;
    if (w_run && r_first) begin
      r_shift <= r_buf;
      r_inv   <= r_inv_buf;
    end else if (w_show && ce_pixel) begin
      if (r_pix == 3'd7) begin
        r_shift <= r_buf;
        r_inv   <= r_inv_buf;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_osd_text_scanout.sv
module tb_osd_text_scanout;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int CH     = 8;
  localparam int BASE_M = 'h100;
  localparam int BASE_W = 'hFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce, fs, ls, ls_w;

  logic [15:0] va;   logic vrd;   logic [7:0] vdat;
  logic [9:0]  fa;   logic frd;   logic [7:0] fdat;
  logic pix, act, done;

  logic [15:0] wva;  logic wvrd;  logic [7:0] wvdat;
  logic [9:0]  wfa;  logic wfrd;  logic [7:0] wfdat;
  logic wpix, wact, wdone;

  osd_text_scanout #(.ADDR_WIDTH(16), .BASE(BASE_M), .COLS(COLS), .ROWS(ROWS), .CHAR_H(CH)) u_dut (
    .clk(clk), .reset(reset), .ce_pixel(ce), .frame_start(fs), .line_start(ls),
    .vram_addr(va), .vram_rd(vrd), .vram_data(vdat),
    .font_addr(fa), .font_rd(frd), .font_data(fdat),
    .pixel(pix), .active(act), .frame_done(done));

  osd_text_scanout #(.ADDR_WIDTH(16), .BASE(BASE_W), .COLS(COLS), .ROWS(ROWS), .CHAR_H(CH)) u_wrap (
    .clk(clk), .reset(reset), .ce_pixel(ce), .frame_start(fs), .line_start(ls_w),
    .vram_addr(wva), .vram_rd(wvrd), .vram_data(wvdat),
    .font_addr(wfa), .font_rd(wfrd), .font_data(wfdat),
    .pixel(wpix), .active(wact), .frame_done(wdone));

  logic [7:0] vmem [0:65535];
  logic [7:0] fmem [0:1023];

  // Synchronous memories: data appears the clk after the request.
  always @(posedge clk) begin
    if (vrd)  vdat  <= vmem[va];
    if (frd)  fdat  <= fmem[fa];
    if (wvrd) wvdat <= vmem[wva];
    if (wfrd) wfdat <= fmem[wfa];
  end

  // Monitor
  bit          mon_sel;
  logic [15:0] q_va [$];
  logic [9:0]  q_fa [$];
  bit          q_px [$];
  int          act_cnt;

  always @(negedge clk) begin
    if (mon_sel ? wvrd : vrd) q_va.push_back(mon_sel ? wva : va);
    if (mon_sel ? wfrd : frd) q_fa.push_back(mon_sel ? wfa : fa);
    if ((mon_sel ? wact : act) && ce) q_px.push_back(mon_sel ? wpix : pix);
    if (mon_sel ? wact : act) act_cnt++;
  end

  // Random pixel enables, never closer than every 2 clk.
  initial begin
    int gap;
    ce = 1'b0;
    gap = 1;
    forever begin
      @(posedge clk);
      #1;
      if (gap == 0) begin
        ce  = 1'b1;
        gap = $urandom_range(1, 3);
      end else begin
        ce  = 1'b0;
        gap--;
      end
    end
  end

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  logic [31:0] last_pix;
  logic [9:0]  last_fa0;

  task automatic pulse_fs();
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
  endtask

  // mode: 0 normal, 1 extra line_start mid-line, 2 abort via frame_start,
  //       3 frame_start together with line_start
  task automatic do_line(input int L, input int mode, input bit wr);
    int row, scan, cyc, b0, n0;
    bit seen, ended, fired, a_now;
    logic [31:0] ew, ow;
    logic [7:0]  code;
    logic [15:0] a;
    logic [9:0]  fexp;
    row = L / CH;
    scan = L % CH;
    b0 = wr ? BASE_W : BASE_M;
    q_va.delete(); q_fa.delete(); q_px.delete();
    mon_sel = wr;
    @(posedge clk); #1;
    if (wr) ls_w = 1'b1; else ls = 1'b1;
    if (mode == 3) fs = 1'b1;
    @(posedge clk); #1;
    ls = 1'b0; ls_w = 1'b0; fs = 1'b0;
    seen = 0; ended = 0; fired = 0; cyc = 0;
    while (!ended && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      a_now = wr ? wact : act;
      if (a_now) seen = 1;
      else if (seen) ended = 1;
      if (mode == 1 && !fired && q_px.size() >= 12) begin
        fired = 1;
        ls = 1'b1;
        @(negedge clk);
        ls = 1'b0;
      end
      if (mode == 2 && !fired && q_px.size() >= 20) begin
        fired = 1;
        fs = 1'b1;
        @(posedge clk); #1 fs = 1'b0;
        check("abort_active", act, 0);
        check("abort_pixel", pix, 0);
        ended = 1;
      end
    end
    check("line_end", ended, 1);
    if (mode == 2) begin
      n0 = q_va.size();
      repeat (40) @(negedge clk);
      check("abort_no_fetch", q_va.size(), n0);
      check("abort_frame_done", done, 0);
    end else begin
      repeat (10) @(negedge clk);
      check("n_vram_rd", q_va.size(), COLS);
      check("n_font_rd", q_fa.size(), COLS);
      check("n_pixels", q_px.size(), COLS * 8);
      ew = '0;
      ow = '0;
      for (int c = 0; c < COLS; c++) begin
        a = 16'(b0 + row * COLS + c);
        code = vmem[a];
        fexp = {code[6:0], 3'(scan)};
        if (c < q_va.size()) check("vram_addr", q_va[c], a);
        if (c < q_fa.size()) check("font_addr", q_fa[c], fexp);
        for (int b = 7; b >= 0; b--) ew = {ew[30:0], fmem[fexp][b] ^ code[7]};
      end
      for (int i = 0; i < q_px.size() && i < 32; i++) ow = {ow[30:0], q_px[i]};
      check("pixels", ow, ew);
      last_pix = ow;
      last_fa0 = (q_fa.size() > 0) ? q_fa[0] : 10'h3FF;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, cyc;
    n_chk = 0; n_pass = 0; act_cnt = 0; mon_sel = 0;
    for (int i = 0; i < 65536; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++)  fmem[i] = 8'($urandom);
    reset = 1'b1; fs = 1'b0; ls = 1'b0; ls_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vram_rd", vrd, 0);
    check("rst_vram_addr", va, 0);
    check("rst_font_rd", frd, 0);
    check("rst_font_addr", fa, 0);
    check("rst_pixel", pix, 0);
    check("rst_active", act, 0);
    check("rst_frame_done", done, 0);
    check("rst_wrap_active", wact, 0);
    reset = 1'b0;

    // Single character pattern
    vmem['h100] = 8'h41;
    fmem['h208] = 8'hA5;
    do_line(0, 0, 0);
    check("t1_pixels", last_pix[31:24], 8'hA5);
    check("t1_font_addr", last_fa0, 10'h208);

    // Inverse video, started together with frame_start
    vmem['h100] = 8'hC1;
    do_line(0, 3, 0);
    check("t2_pixels", last_pix[31:24], 8'h5A);
    check("t2_font_addr", last_fa0, 10'h208);

    // Full frame with random contents; one busy line_start on line 5
    for (int i = 'h100; i < 'h108; i++) vmem[i] = 8'($urandom);
    pulse_fs();
    for (int L = 0; L < ROWS * CH; L++) begin
      if (L == ROWS * CH - 1) check("done_before_last", done, 0);
      do_line(L, (L == 5) ? 1 : 0, 0);
    end
    check("frame_done", done, 1);
    q_va.delete();
    n0 = act_cnt;
    @(posedge clk); #1 ls = 1'b1;
    @(posedge clk); #1 ls = 1'b0;
    repeat (40) @(negedge clk);
    check("after_done_no_fetch", q_va.size(), 0);
    check("after_done_no_active", act_cnt - n0, 0);

    // Mid-line abort, then a clean line from row 0 / scan 0
    pulse_fs();
    check("fs_clears_done", done, 0);
    do_line(0, 2, 0);
    do_line(0, 0, 0);

    // Asynchronous reset mid-line
    q_px.delete();
    @(posedge clk); #1 ls = 1'b1;
    @(posedge clk); #1 ls = 1'b0;
    cyc = 0;
    while (q_px.size() < 10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_pixels", q_px.size() >= 10, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_active", act, 0);
    check("async_rst_pixel", pix, 0);
    check("async_rst_vram_rd", vrd, 0);
    check("async_rst_font_rd", frd, 0);
    @(posedge clk); #1 reset = 1'b0;
    do_line(0, 0, 0);

    // Address wrap on the second instance
    pulse_fs();
    do_line(0, 0, 1);
    check("wrap_addr2", (q_va.size() > 2) ? q_va[2] : 16'hDEAD, 16'h0000);
    mon_sel = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
